// File: rtl/multihand_datapath_if.sv
// Deal/clear handshake between the baccarat controller (master) and the hand datapath (slave).
interface multihand_datapath_if #(
    parameter int NUM_HANDS = 2
);
    localparam int HW = (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1;

    logic [3:0]    new_card;
    logic          deal_req;
    logic [HW-1:0] deal_hand;
    logic          clear_req;
    logic          busy;
    logic          deal_done;
    logic          deal_reject;

    modport master (
        output new_card, deal_req, deal_hand, clear_req,
        input  busy, deal_done, deal_reject
    );

    modport slave (
        input  new_card, deal_req, deal_hand, clear_req,
        output busy, deal_done, deal_reject
    );
endinterface

// File: rtl/multihand_datapath.sv
// Card-hand storage for the baccarat table: per-hand card slots, counts and an
// incrementally maintained modulo-10 score, fed by a deal/clear handshake.
//
//   state | meaning
//   IDLE  | waiting for deal_req or clear_req
//   SCORE | card stored, folding its value into the latched hand's score
module multihand_datapath #(
    parameter int  NUM_HANDS = 2,
    parameter int  MAX_CARDS = 3,
    localparam int HW = (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1,
    localparam int CW = $clog2(MAX_CARDS + 1)
) (
    input  logic                            slow_clock,
    input  logic                            resetb,
    multihand_datapath_if.slave             hs,
    output logic [NUM_HANDS*MAX_CARDS*4-1:0] cards,
    output logic [NUM_HANDS*CW-1:0]         count,
    output logic [NUM_HANDS*4-1:0]          score,
    output logic [NUM_HANDS-1:0]            natural
);
    localparam logic [HW:0]   NH_L  = NUM_HANDS[HW:0];
    localparam logic [CW-1:0] MAX_L = MAX_CARDS[CW-1:0];
    localparam logic [CW-1:0] TWO_L = CW'(2);

    typedef enum logic {IDLE, SCORE} state_t;

    state_t        state;
    logic [3:0]    slot_q [NUM_HANDS][MAX_CARDS];
    logic [CW-1:0] cnt_q  [NUM_HANDS];
    logic [3:0]    scr_q  [NUM_HANDS];
    logic [HW-1:0] hand_q;
    logic [3:0]    val_q;
    logic          busy_q;
    logic          done_q;
    logic          rej_q;

    logic          hand_ok;
    logic          room_ok;
    logic          card_ok;
    logic          accept;
    logic [CW-1:0] cur_cnt;
    logic [3:0]    card_val;
    logic [4:0]    sum;

    always_comb begin
        hand_ok  = {1'b0, hs.deal_hand} < NH_L;
        cur_cnt  = hand_ok ? cnt_q[hs.deal_hand] : '0;
        room_ok  = cur_cnt < MAX_L;
        card_ok  = (hs.new_card >= 4'd1) && (hs.new_card <= 4'd13);
        accept   = hand_ok && room_ok && card_ok;
        card_val = (hs.new_card < 4'd10) ? hs.new_card : 4'd0;
        sum      = {1'b0, scr_q[hand_q]} + {1'b0, val_q};
    end

    // Clear shares the reset path: it wins over any deal and aborts a pending update.
    always_ff @(posedge slow_clock) begin
        if (!resetb || hs.clear_req) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            rej_q  <= 1'b0;
            hand_q <= '0;
            val_q  <= '0;
            for (int h = 0; h < NUM_HANDS; h++) begin
                cnt_q[h] <= '0;
                scr_q[h] <= '0;
                for (int s = 0; s < MAX_CARDS; s++) slot_q[h][s] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            rej_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (hs.deal_req) begin
                        if (accept) begin
                            slot_q[hs.deal_hand][cur_cnt] <= hs.new_card;
                            cnt_q[hs.deal_hand]           <= cur_cnt + CW'(1);
                            hand_q <= hs.deal_hand;
                            val_q  <= card_val;
                            busy_q <= 1'b1;
                            state  <= SCORE;
                        end else begin
                            rej_q <= 1'b1;
                        end
                    end
                end
                SCORE: begin
                    scr_q[hand_q] <= (sum >= 5'd10) ? 4'(sum - 5'd10) : sum[3:0];
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign hs.busy        = busy_q;
    assign hs.deal_done   = done_q;
    assign hs.deal_reject = rej_q;

    always_comb begin
        cards   = '0;
        count   = '0;
        score   = '0;
        natural = '0;
        for (int h = 0; h < NUM_HANDS; h++) begin
            for (int s = 0; s < MAX_CARDS; s++) cards[(h*MAX_CARDS+s)*4 +: 4] = slot_q[h][s];
            count[h*CW +: CW] = cnt_q[h];
            score[h*4 +: 4]   = scr_q[h];
            natural[h]        = (cnt_q[h] == TWO_L) && (scr_q[h] >= 4'd8);
        end
    end
endmodule

// File: tb/tb_multihand_datapath.sv
// Self-checking bench for multihand_datapath: a 2x3 table and a 5x7 table checked
// against a card-list model whose scores are recomputed from scratch.
module tb_multihand_datapath;
    localparam int NA = 2, MA = 3, CWA = 2, HWA = 1;
    localparam int NB = 5, MB = 7, CWB = 3, HWB = 3;

    logic slow_clock = 1'b0;
    logic resetb_a   = 1'b0;
    logic resetb_b   = 1'b0;
    int   n_checks   = 0;
    int   n_errors   = 0;

    always #5 slow_clock = ~slow_clock;

    multihand_datapath_if #(.NUM_HANDS(NA)) hs_a ();
    multihand_datapath_if #(.NUM_HANDS(NB)) hs_b ();

    logic [NA*MA*4-1:0] cards_a;
    logic [NA*CWA-1:0]  count_a;
    logic [NA*4-1:0]    score_a;
    logic [NA-1:0]      natural_a;
    logic [NB*MB*4-1:0] cards_b;
    logic [NB*CWB-1:0]  count_b;
    logic [NB*4-1:0]    score_b;
    logic [NB-1:0]      natural_b;

    multihand_datapath #(.NUM_HANDS(NA), .MAX_CARDS(MA)) dut_a (
        .slow_clock(slow_clock), .resetb(resetb_a), .hs(hs_a),
        .cards(cards_a), .count(count_a), .score(score_a), .natural(natural_a)
    );

    multihand_datapath #(.NUM_HANDS(NB), .MAX_CARDS(MB)) dut_b (
        .slow_clock(slow_clock), .resetb(resetb_b), .hs(hs_b),
        .cards(cards_b), .count(count_b), .score(score_b), .natural(natural_b)
    );

    // Model: ordered card list per hand; index 0 is the 2x3 table, 1 the 5x7 table.
    logic [3:0] m_card [2][8][7];
    int         m_cnt  [2][8];

    function automatic int nh(input int i);  return (i == 0) ? NA : NB;   endfunction
    function automatic int mc(input int i);  return (i == 0) ? MA : MB;   endfunction
    function automatic int cwf(input int i); return (i == 0) ? CWA : CWB; endfunction

    function automatic int value(input logic [3:0] c);
        return (c < 4'd10) ? int'(c) : 0;
    endfunction

    function automatic int hand_score(input int i, input int h);
        int sum = 0;
        for (int s = 0; s < m_cnt[i][h]; s++) sum += value(m_card[i][h][s]);
        return sum % 10;
    endfunction

    task automatic model_clear(input int i);
        for (int h = 0; h < 8; h++) begin
            m_cnt[i][h] = 0;
            for (int s = 0; s < 7; s++) m_card[i][h][s] = 4'd0;
        end
    endtask

    function automatic bit model_deal(input int i, input logic [3:0] c, input int h);
        if (h >= nh(i) || m_cnt[i][h] >= mc(i) || c < 4'd1 || c > 4'd13) return 1'b0;
        m_card[i][h][m_cnt[i][h]] = c;
        m_cnt[i][h]++;
        return 1'b1;
    endfunction

    function automatic logic [223:0] exp_cards(input int i);
        logic [223:0] r = '0;
        for (int h = 0; h < nh(i); h++)
            for (int s = 0; s < m_cnt[i][h]; s++) r[(h*mc(i)+s)*4 +: 4] = m_card[i][h][s];
        return r;
    endfunction

    function automatic logic [23:0] exp_count(input int i);
        logic [23:0] r = '0;
        for (int h = 0; h < nh(i); h++)
            for (int b = 0; b < cwf(i); b++) r[h*cwf(i)+b] = 1'((m_cnt[i][h] >> b) & 1);
        return r;
    endfunction

    function automatic logic [31:0] exp_score(input int i);
        logic [31:0] r = '0;
        for (int h = 0; h < nh(i); h++) r[h*4 +: 4] = 4'(hand_score(i, h));
        return r;
    endfunction

    function automatic logic [7:0] exp_nat(input int i);
        logic [7:0] r = '0;
        for (int h = 0; h < nh(i); h++) r[h] = (m_cnt[i][h] == 2) && (hand_score(i, h) >= 8);
        return r;
    endfunction

    function automatic logic [287:0] exp_state(input int i);
        return {exp_cards(i), exp_count(i), exp_score(i), exp_nat(i)};
    endfunction

    function automatic logic [287:0] dut_state(input int i);
        if (i == 0) return {224'(cards_a), 24'(count_a), 32'(score_a), 8'(natural_a)};
        return {224'(cards_b), 24'(count_b), 32'(score_b), 8'(natural_b)};
    endfunction

    function automatic logic [2:0] flags(input int i);
        if (i == 0) return {hs_a.busy, hs_a.deal_done, hs_a.deal_reject};
        return {hs_b.busy, hs_b.deal_done, hs_b.deal_reject};
    endfunction

    task automatic drive(input int i, input logic [3:0] c, input int h, input logic req, input logic clr);
        if (i == 0) begin
            hs_a.new_card = c; hs_a.deal_hand = HWA'(h); hs_a.deal_req = req; hs_a.clear_req = clr;
        end else begin
            hs_b.new_card = c; hs_b.deal_hand = HWB'(h); hs_b.deal_req = req; hs_b.clear_req = clr;
        end
    endtask

    // One request, then four cycles of observation; new_card is scrambled after the accepting edge.
    task automatic deal(input int i, input logic [3:0] c, input int h,
                        output int dn, output int da, output int rn, output int ra,
                        output logic busy1, output logic [287:0] mid);
        logic [2:0] f;
        @(negedge slow_clock);
        drive(i, c, h, 1'b1, 1'b0);
        dn = 0; da = 0; rn = 0; ra = 0; busy1 = 1'b0; mid = '0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge slow_clock);
            f = flags(i);
            if (k == 1) begin
                busy1 = f[2];
                mid   = dut_state(i);
                drive(i, 4'($urandom), h, 1'b0, 1'b0);
            end
            if (f[1]) begin dn++; if (da == 0) da = k; end
            if (f[0]) begin rn++; if (ra == 0) ra = k; end
        end
    endtask

    task automatic test_reset();
        drive(0, 4'd0, 0, 1'b0, 1'b0);
        drive(1, 4'd0, 0, 1'b0, 1'b0);
        resetb_a = 1'b0; resetb_b = 1'b0;
        repeat (3) @(negedge slow_clock);
        resetb_a = 1'b1; resetb_b = 1'b1;
        model_clear(0); model_clear(1);
        @(negedge slow_clock);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (dut_state(i) !== exp_state(i)) begin
                n_errors++; $display("FAIL reset_state[%0d]: got %h expected %h", i, dut_state(i), exp_state(i));
            end
            n_checks++;
            if (flags(i) !== 3'b000) begin
                n_errors++; $display("FAIL reset_flags[%0d]: got %b expected 000", i, flags(i));
            end
        end
    endtask

    // Generic per-deal comparisons shared by the scenario loops below are written inline in each.
    task automatic test_natural();
        logic [3:0] seq [2] = '{4'd7, 4'd2};
        int dn, da, rn, ra; logic b1; logic [287:0] mid; logic [31:0] pre; bit acc;
        for (int k = 0; k < 2; k++) begin
            pre = exp_score(0);
            acc = model_deal(0, seq[k], 0);
            deal(0, seq[k], 0, dn, da, rn, ra, b1, mid);
            n_checks++;
            if ({dn, da, rn, ra} !== (acc ? {32'd1, 32'd2, 32'd0, 32'd0} : {32'd0, 32'd0, 32'd1, 32'd1})) begin
                n_errors++; $display("FAIL natural_pulses: got done %0d@%0d rej %0d@%0d accept %0d", dn, da, rn, ra, acc);
            end
            n_checks++;
            if ({b1, mid[287:8]} !== {acc, exp_cards(0), exp_count(0), pre}) begin
                n_errors++; $display("FAIL natural_mid: got %h expected %h", {b1, mid[287:8]}, {acc, exp_cards(0), exp_count(0), pre});
            end
        end
        n_checks++;
        if ({natural_a, score_a[3:0], count_a[1:0]} !== {2'b01, 4'd9, 2'd2}) begin
            n_errors++; $display("FAIL natural_hand0: got nat %b score %0d count %0d expected 01 9 2", natural_a, score_a[3:0], count_a[1:0]);
        end
    endtask

    task automatic test_full_hand();
        logic [3:0] seq [4] = '{4'd9, 4'd8, 4'd6, 4'd13};
        int exp_sc [3] = '{9, 7, 3};
        int dn, da, rn, ra; logic b1; logic [287:0] mid; bit acc;
        for (int k = 0; k < 4; k++) begin
            acc = model_deal(0, seq[k], 1);
            deal(0, seq[k], 1, dn, da, rn, ra, b1, mid);
            n_checks++;
            if ({dn, da, rn, ra} !== (acc ? {32'd1, 32'd2, 32'd0, 32'd0} : {32'd0, 32'd0, 32'd1, 32'd1})) begin
                n_errors++; $display("FAIL full_pulses[%0d]: got done %0d@%0d rej %0d@%0d accept %0d", k, dn, da, rn, ra, acc);
            end
            n_checks++;
            if (dut_state(0) !== exp_state(0)) begin
                n_errors++; $display("FAIL full_state[%0d]: got %h expected %h", k, dut_state(0), exp_state(0));
            end
            if (k < 3) begin
                n_checks++;
                if (score_a[7:4] !== 4'(exp_sc[k])) begin
                    n_errors++; $display("FAIL full_score[%0d]: got %0d expected %0d", k, score_a[7:4], exp_sc[k]);
                end
            end
        end
        n_checks++;
        if (count_a[3:2] !== 2'd3) begin
            n_errors++; $display("FAIL full_count: got %0d expected 3", count_a[3:2]);
        end
    endtask

    task automatic test_invalid();
        logic [3:0] bad_cards [3] = '{4'd0, 4'd14, 4'd15};
        int dn, da, rn, ra; logic b1; logic [287:0] mid;
        for (int k = 0; k < 6; k++) begin
            int i = (k < 3) ? 0 : 1;
            logic [3:0] c = (k < 3) ? bad_cards[k] : 4'($urandom_range(1, 13));
            int h = (k < 3) ? 0 : 5 + (k - 3);
            n_checks++;
            if (model_deal(i, c, h) != 1'b0) begin
                n_errors++; $display("FAIL invalid_model[%0d]: got accept expected reject", k);
            end
            deal(i, c, h, dn, da, rn, ra, b1, mid);
            n_checks++;
            if ({b1, dn, rn, ra} !== {1'b0, 32'd0, 32'd1, 32'd1}) begin
                n_errors++; $display("FAIL invalid_pulses[%0d]: got busy %b done %0d rej %0d@%0d expected 0 0 1@1", k, b1, dn, rn, ra);
            end
            n_checks++;
            if (dut_state(i) !== exp_state(i)) begin
                n_errors++; $display("FAIL invalid_state[%0d]: got %h expected %h", k, dut_state(i), exp_state(i));
            end
        end
    endtask

    task automatic test_clear();
        int dn, da, rn, ra; logic b1; logic [287:0] mid; logic seen;
        @(negedge slow_clock);
        drive(0, 4'd5, 0, 1'b1, 1'b0);
        @(negedge slow_clock);
        drive(0, 4'd5, 0, 1'b0, 1'b1);
        @(negedge slow_clock);
        drive(0, 4'd5, 0, 1'b0, 1'b0);
        model_clear(0);
        seen = hs_a.deal_done;
        n_checks++;
        if ({dut_state(0), flags(0)} !== {exp_state(0), 3'b000}) begin
            n_errors++; $display("FAIL clear_in_score: got %h expected %h", {dut_state(0), flags(0)}, {exp_state(0), 3'b000});
        end
        @(negedge slow_clock);
        seen |= hs_a.deal_done;
        n_checks++;
        if (seen !== 1'b0) begin
            n_errors++; $display("FAIL clear_no_done: got %b expected 0", seen);
        end
        void'(model_deal(0, 4'd4, 1));
        deal(0, 4'd4, 1, dn, da, rn, ra, b1, mid);
        drive(0, 4'd6, 0, 1'b1, 1'b1);
        @(negedge slow_clock);
        drive(0, 4'd6, 0, 1'b0, 1'b0);
        model_clear(0);
        n_checks++;
        if ({dut_state(0), flags(0)} !== {exp_state(0), 3'b000}) begin
            n_errors++; $display("FAIL clear_wins: got %h expected %h", {dut_state(0), flags(0)}, {exp_state(0), 3'b000});
        end
    endtask

    task automatic test_reset_mid_score();
        int dn, da, rn, ra; logic b1; logic [287:0] mid; logic seen; bit acc;
        void'(model_deal(0, 4'd3, 0));
        deal(0, 4'd3, 0, dn, da, rn, ra, b1, mid);
        drive(0, 4'd8, 1, 1'b1, 1'b0);
        @(negedge slow_clock);
        drive(0, 4'd8, 1, 1'b0, 1'b0);
        resetb_a = 1'b0;
        @(negedge slow_clock);
        resetb_a = 1'b1;
        model_clear(0);
        seen = hs_a.deal_done;
        n_checks++;
        if ({dut_state(0), flags(0)} !== {exp_state(0), 3'b000}) begin
            n_errors++; $display("FAIL reset_mid_state: got %h expected %h", {dut_state(0), flags(0)}, {exp_state(0), 3'b000});
        end
        @(negedge slow_clock);
        seen |= hs_a.deal_done;
        n_checks++;
        if (seen !== 1'b0) begin
            n_errors++; $display("FAIL reset_mid_no_done: got %b expected 0", seen);
        end
        acc = model_deal(0, 4'd11, 1);
        deal(0, 4'd11, 1, dn, da, rn, ra, b1, mid);
        n_checks++;
        if ({acc, dn, da, rn} !== {1'b1, 32'd1, 32'd2, 32'd0} || dut_state(0) !== exp_state(0)) begin
            n_errors++; $display("FAIL reset_mid_next: got done %0d@%0d rej %0d state %h expected %h", dn, da, rn, dut_state(0), exp_state(0));
        end
    endtask

    task automatic test_random();
        int dn, da, rn, ra; logic b1; logic [287:0] mid; logic [31:0] pre; bit acc;
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 9) == 0) begin
                @(negedge slow_clock);
                drive(0, 4'd0, 0, 1'b0, 1'b1);
                @(negedge slow_clock);
                drive(0, 4'd0, 0, 1'b0, 1'b0);
                model_clear(0);
            end else begin
                logic [3:0] c = 4'($urandom_range(0, 15));
                int h = $urandom_range(0, NA - 1);
                pre = exp_score(0);
                acc = model_deal(0, c, h);
                deal(0, c, h, dn, da, rn, ra, b1, mid);
                n_checks++;
                if ({dn, da, rn, ra} !== (acc ? {32'd1, 32'd2, 32'd0, 32'd0} : {32'd0, 32'd0, 32'd1, 32'd1})) begin
                    n_errors++; $display("FAIL random_pulses[%0d]: card %0d hand %0d got done %0d@%0d rej %0d@%0d", k, c, h, dn, da, rn, ra);
                end
                n_checks++;
                if ({b1, mid[287:8]} !== {acc, exp_cards(0), exp_count(0), pre}) begin
                    n_errors++; $display("FAIL random_mid[%0d]: got %h expected %h", k, {b1, mid[287:8]}, {acc, exp_cards(0), exp_count(0), pre});
                end
            end
            n_checks++;
            if (dut_state(0) !== exp_state(0)) begin
                n_errors++; $display("FAIL random_state[%0d]: got %h expected %h", k, dut_state(0), exp_state(0));
            end
        end
    endtask

    task automatic test_seven_cards();
        int dn, da, rn, ra; logic b1; logic [287:0] mid; bit acc;
        for (int k = 0; k < 8; k++) begin
            acc = model_deal(1, 4'd9, 4);
            deal(1, 4'd9, 4, dn, da, rn, ra, b1, mid);
            n_checks++;
            if ({dn, rn} !== ((k < 7) ? {32'd1, 32'd0} : {32'd0, 32'd1}) || acc !== (k < 7)) begin
                n_errors++; $display("FAIL seven_pulses[%0d]: got done %0d rej %0d", k, dn, rn);
            end
            if (k < 7) begin
                n_checks++;
                if ({score_b[19:16], count_b[14:12]} !== {4'((9 * (k + 1)) % 10), 3'(k + 1)}) begin
                    n_errors++; $display("FAIL seven_score[%0d]: got %0d/%0d expected %0d/%0d", k, score_b[19:16], count_b[14:12], (9 * (k + 1)) % 10, k + 1);
                end
            end
            n_checks++;
            if (dut_state(1) !== exp_state(1)) begin
                n_errors++; $display("FAIL seven_state[%0d]: got %h expected %h", k, dut_state(1), exp_state(1));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] c; int h; logic [31:0] pre;
        @(negedge slow_clock);
        drive(1, 4'd0, 0, 1'b0, 1'b1);
        @(negedge slow_clock);
        model_clear(1);
        c = 4'($urandom_range(1, 13)); h = $urandom_range(0, NB - 1);
        drive(1, c, h, 1'b1, 1'b0);
        for (int k = 0; k < 20; k++) begin
            pre = exp_score(1);
            void'(model_deal(1, c, h));
            @(negedge slow_clock);
            drive(1, 4'($urandom), h, 1'b0, 1'b0);
            n_checks++;
            if ({flags(1), dut_state(1)[287:8]} !== {3'b100, exp_cards(1), exp_count(1), pre}) begin
                n_errors++; $display("FAIL b2b_mid[%0d]: got %h expected %h", k, {flags(1), dut_state(1)[287:8]}, {3'b100, exp_cards(1), exp_count(1), pre});
            end
            @(negedge slow_clock);
            n_checks++;
            if ({flags(1), dut_state(1)} !== {3'b010, exp_state(1)}) begin
                n_errors++; $display("FAIL b2b_done[%0d]: got %h expected %h", k, {flags(1), dut_state(1)}, {3'b010, exp_state(1)});
            end
            if (k < 19) begin
                c = 4'($urandom_range(1, 13));
                h = $urandom_range(0, NB - 1);
                while (m_cnt[1][h] >= MB) h = (h + 1) % NB;
                drive(1, c, h, 1'b1, 1'b0);
            end
        end
        @(negedge slow_clock);
        n_checks++;
        if (flags(1) !== 3'b000) begin
            n_errors++; $display("FAIL b2b_tail: got %b expected 000", flags(1));
        end
    endtask

    initial begin
        test_reset();
        test_natural();
        test_full_hand();
        test_invalid();
        test_clear();
        test_reset_mid_score();
        test_random();
        test_seven_cards();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
